// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths and the register-file clear FSM state type.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-side bus of the multi-port register file: two write ports, packed reads, clear control.
interface reg_file_mp_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);

  logic                     WRITE0;
  logic [ADDR_W-1:0]        INADDRESS0;
  logic [DATA_W-1:0]        IN0;
  logic                     WRITE1;
  logic [ADDR_W-1:0]        INADDRESS1;
  logic [DATA_W-1:0]        IN1;
  logic [NUM_RD*ADDR_W-1:0] RDADDRESS;
  logic [NUM_RD*DATA_W-1:0] OUT;
  logic                     CLEAR;
  logic                     BUSY;

  modport master (
    output WRITE0, INADDRESS0, IN0,
    output WRITE1, INADDRESS1, IN1,
    output RDADDRESS, CLEAR,
    input  OUT, BUSY
  );

  modport slave (
    input  WRITE0, INADDRESS0, IN0,
    input  WRITE1, INADDRESS1, IN1,
    input  RDADDRESS, CLEAR,
    output OUT, BUSY
  );

endinterface

// File: rtl/reg_clear_seq.sv
// Sequential clear engine: walks registers 0..DEPTH-1, zeroing one per cycle while BUSY is high.
module reg_clear_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A CLEAR seen while already clearing is ignored; the walk never restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    BUSY      = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (CLEAR) begin
          state_nxt = CLEARING;
          cnt_nxt   = '0;
        end
      end
      CLEARING: begin
        BUSY   = 1'b1;
        clr_en = 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port CPU register file: two write ports, NUM_RD combinational read ports with optional
// write-to-read bypass, optional hardwired-zero r0 and a sequential clear engine.
module reg_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_mp_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic                     busy;
  logic                     clr_en;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     we0, we1;
  logic [NUM_RD*DATA_W-1:0] out_v;

  // True when the address maps to a real, writable/readable register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  reg_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    (bus.CLEAR),
    .BUSY     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign we0 = bus.WRITE0 && addr_live(bus.INADDRESS0) && !busy;
  assign we1 = bus.WRITE1 && addr_live(bus.INADDRESS1) && !busy;

  // Port 1 is assigned last so it wins a same-address conflict.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_en) begin
      regs[IDX_W'(clr_addr)] <= '0;
    end else begin
      if (we0) regs[IDX_W'(bus.INADDRESS0)] <= bus.IN0;
      if (we1) regs[IDX_W'(bus.INADDRESS1)] <= bus.IN1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    out_v = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.RDADDRESS[k*ADDR_W +: ADDR_W];
      rd = '0;
      if (addr_live(ra)) rd = regs[IDX_W'(ra)];
      // we0/we1 already fold in range, zero-register and busy gating.
      if (BYPASS != 0) begin
        if (we0 && (bus.INADDRESS0 == ra)) rd = bus.IN0;
        if (we1 && (bus.INADDRESS1 == ra)) rd = bus.IN1;
      end
      out_v[k*DATA_W +: DATA_W] = rd;
    end
  end

  assign bus.OUT  = out_v;
  assign bus.BUSY = busy;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port CPU register file, the next generation of the single-write/dual-read register file. Generalises data width, depth and read-port count, and adds:
- a second write port
- optional same-cycle write-to-read bypass
- optional hardwired-zero register 0
- a sequential clear engine that replaces the old single-cycle bulk reset

Sits between decode (read addresses) and writeback (write ports) in the CPU datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of registers; must satisfy 2 <= DEPTH <= 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
WRITE0  in  1  write enable, port 0
INADDRESS0  in  ADDR_W  write address, port 0
IN0  in  DATA_W  write data, port 0
WRITE1  in  1  write enable, port 1
INADDRESS1  in  ADDR_W  write address, port 1
IN1  in  DATA_W  write data, port 1
RDADDRESS  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
OUT  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
CLEAR  in  1  request sequential clear of all registers
BUSY  out  1  clear engine active

Behaviour:
- RESET low (asynchronous): all registers become 0, FSM goes to IDLE, clear counter 0, BUSY 0. This takes effect immediately and holds while RESET is low. No #-delays anywhere; the design is fully synthesizable.
- Reads are combinational (zero-cycle latency):
  - OUT[k] = registers[RDADDRESS[k]].
  - Address >= DEPTH reads 0.
  - Address 0 reads 0 when ZERO_REG=1.
- Writes commit on the rising CLK edge; data is visible on OUT in the following cycle (or the same cycle via bypass).
  - Writes are ignored when the address is >= DEPTH, when the address is 0 with ZERO_REG=1, or when BUSY=1.
- Write conflict: WRITE0 and WRITE1 to the same address in the same cycle → port 1 value is stored.
- Bypass (BYPASS=1, BUSY=0):
  - If a valid write targets RDADDRESS[k] this cycle, OUT[k] shows the write data combinationally.
  - Port 1 has priority over port 0.
  - Bypass obeys the zero-register and out-of-range rules.
- Clear FSM, states IDLE and CLEARING:
  - IDLE: CLEAR=1 at an edge → CLEARING, counter=0, BUSY=1 from the next cycle. Writes in that same cycle still commit.
  - CLEARING: each edge zeroes registers[counter], then counter+1. When counter==DEPTH-1 the edge zeroes the last register and returns to IDLE; BUSY drops after that edge.
  - BUSY is therefore high for exactly DEPTH cycles.
  - CLEAR during CLEARING is ignored; there is no restart.
  - During CLEARING, reads return current stored contents, a mix of cleared and uncleared values. Bypass is disabled.
  - Counter width is ADDR_W bits and never wraps past DEPTH-1.
- RESET low during CLEARING: abort immediately and enter the reset state. No clear resumes after release.

Decomposition:
- Shared package (cpu_pkg): DATA_W and ADDR_W defaults, and a clear-FSM state typedef (IDLE, CLEARING).
- One natural sub-module: reg_clear_seq, containing the FSM, counter and BUSY, with outputs clr_en and clr_addr. The storage array, write arbitration and read/bypass muxes stay in reg_file_mp.

Test Plan:
- Reset: hold RESET=0 for 2 cycles, then release → every read port returns 0 for all addresses 0..31, and BUSY=0.
- Write/read: WRITE0 to addr 5 with IN0=32'hDEADBEEF → after the edge, RDADDRESS port 0 = 5 reads DEADBEEF. Write to addr 0 with 32'h1234 → reads 0 (ZERO_REG=1).
- Bypass: same cycle, WRITE0 to addr 7 with 32'hAAAA and WRITE1 to addr 7 with 32'hBBBB, read port 1 = 7 → OUT shows BBBB before the edge, and addr 7 holds BBBB after it.
- Clear: fill regs 1..31 with nonzero values, pulse CLEAR for 1 cycle → BUSY high for exactly 32 cycles. A WRITE0 issued mid-clear is dropped. After BUSY falls, all registers read 0.
- Reset mid-clear: pulse CLEAR, assert RESET low on clear cycle 10 → BUSY=0 immediately and all registers 0. After release the FSM is IDLE, and a new write then read works normally.
- Parameter sweep: DATA_W=16, DEPTH=8, NUM_RD=3 → a write to addr 9 is ignored, address 9 reads 0, and the clear runs 8 cycles.
